// File: rtl/uart_pkg.sv
// Shared constants for the UART report scheduler: command bytes, pending-bit
// indices, auto-report period limits, issue FSM encoding and small helpers.
// Ports: none (package only).
package uart_pkg;

  // Command bytes, lower case; decode folds 'A'..'Z' to lower case first.
  localparam logic [7:0] CMD_WATCH = 8'h77; // 'w'
  localparam logic [7:0] CMD_SR04  = 8'h73; // 's'
  localparam logic [7:0] CMD_TEMP  = 8'h74; // 't'
  localparam logic [7:0] CMD_HUM   = 8'h68; // 'h'
  localparam logic [7:0] CMD_ALL   = 8'h61; // 'a'
  localparam logic [7:0] CMD_AUTO  = 8'h70; // 'p'
  localparam logic [7:0] CMD_ECHO  = 8'h65; // 'e'
  localparam logic [7:0] CMD_PER1  = 8'h31; // '1'
  localparam logic [7:0] CMD_PER2  = 8'h32; // '2'
  localparam logic [7:0] CMD_PER5  = 8'h35; // '5'
  localparam logic [7:0] CHR_CR    = 8'h0D;
  localparam logic [7:0] CHR_LF    = 8'h0A;
  localparam logic [7:0] CHR_SP    = 8'h20;

  localparam int PEND_W = 0;
  localparam int PEND_S = 1;
  localparam int PEND_T = 2;
  localparam int PEND_H = 3;

  localparam logic [12:0] LIM_1000MS = 13'd999;
  localparam logic [12:0] LIM_2000MS = 13'd1999;
  localparam logic [12:0] LIM_5000MS = 13'd4999;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_GAP       = 2'd2,
    ST_WAIT_IDLE = 2'd3
  } sched_state_e;

  // Unused select code 3 falls back to the 1000 ms period.
  function automatic logic [12:0] period_limit(input logic [1:0] sel);
    case (sel)
      2'd1:    period_limit = LIM_2000MS;
      2'd2:    period_limit = LIM_5000MS;
      default: period_limit = LIM_1000MS;
    endcase
  endfunction

  // One-hot of the highest-priority pending bit; lowest index wins (W > S > T > H).
  function automatic logic [3:0] prio_pick(input logic [3:0] m);
    prio_pick = m & (~m + 4'd1);
  endfunction

  function automatic logic [7:0] to_lower(input logic [7:0] c);
    if (c >= 8'h41 && c <= 8'h5A) to_lower = c | 8'h20;
    else                          to_lower = c;
  endfunction

endpackage

// File: rtl/uart_ms_period_timer.sv
// Auto-report period timer: 1 ms prescaler, 13-bit ms counter and period compare.
// Ports: iClk/iRstn, iEn (counting enable), iClr (restart counting),
//        iPeriodSel (0/1/2 = 1000/2000/5000 ms), oPeriodHit (one-cycle pulse per period).
module uart_ms_period_timer
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 100000000
) (
  input  logic       iClk,
  input  logic       iRstn,
  input  logic       iEn,
  input  logic       iClr,
  input  logic [1:0] iPeriodSel,
  output logic       oPeriodHit
);

  localparam int PRE_MAX = CLK_HZ / 1000 - 1;
  localparam int PRE_W   = (PRE_MAX > 0) ? $clog2(PRE_MAX + 1) : 1;

  logic [PRE_W-1:0] pre_q;
  logic [12:0]      ms_q;
  logic             hit_q;

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      pre_q <= '0;
      ms_q  <= '0;
      hit_q <= 1'b0;
    end else begin
      hit_q <= 1'b0;
      // Disabled or restarted: hold at zero so a fresh period starts cleanly.
      if (iClr || !iEn) begin
        pre_q <= '0;
        ms_q  <= '0;
      end else if (pre_q == PRE_W'(PRE_MAX)) begin
        pre_q <= '0;
        if (ms_q == period_limit(iPeriodSel)) begin
          ms_q  <= '0;
          hit_q <= 1'b1;
        end else begin
          ms_q <= ms_q + 13'd1;
        end
      end else begin
        pre_q <= pre_q + 1'b1;
      end
    end
  end

  assign oPeriodHit = hit_q;

endmodule

// File: rtl/uart_report_scheduler.sv
// UART command decode and report request scheduler. Single-byte ASCII commands
// set pending report bits; an issue FSM emits one request pulse at a time,
// spaced by the sender idle status. Optional periodic auto-reports are built
// only when UART_SCHED_AUTO_REPORT_EN is defined.
// Ports: iClk/iRstn, iRxData/iRxValid (RX byte strobe), iSenderIdle,
//        oReq*Report (one-cycle pulses), oLoopEn, oAutoEn, oPeriodSel, oCmdErr.
module uart_report_scheduler
  import uart_pkg::*;
#(
  parameter int         CLK_HZ             = 100000000,
  parameter int         GAP_CYCLES         = 4,
  parameter logic [1:0] DEFAULT_PERIOD_SEL = 2'd0
) (
  input  logic       iClk,
  input  logic       iRstn,
  input  logic [7:0] iRxData,
  input  logic       iRxValid,
  input  logic       iSenderIdle,
  output logic       oReqWatchReport,
  output logic       oReqSr04Report,
  output logic       oReqTempReport,
  output logic       oReqHumReport,
  output logic       oLoopEn,
  output logic       oAutoEn,
  output logic [1:0] oPeriodSel,
  output logic       oCmdErr
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  sched_state_e     state_q;
  logic [GAP_W-1:0] gap_q;
  logic [3:0]       req_q;
  logic [3:0]       pend_q, pend_d;
  logic             loop_q, err_q;
  logic [3:0]       cmd_set, issue_oh, per_set;
  logic             echo_tgl, cmd_err;
  logic [7:0]       rx_lc;

`ifdef UART_SCHED_AUTO_REPORT_EN
  logic       auto_q;
  logic [1:0] sel_q;
  logic       auto_tgl, sel_ld, per_hit;
  logic [1:0] sel_val;

  uart_ms_period_timer #(.CLK_HZ(CLK_HZ)) u_timer (
    .iClk       (iClk),
    .iRstn      (iRstn),
    .iEn        (auto_q),
    .iClr       (auto_tgl | sel_ld),
    .iPeriodSel (sel_q),
    .oPeriodHit (per_hit)
  );

  assign per_set    = {4{per_hit}};
  assign oAutoEn    = auto_q;
  assign oPeriodSel = sel_q;
`else
  assign per_set    = 4'b0000;
  assign oAutoEn    = 1'b0;
  assign oPeriodSel = 2'd0;
`endif

  always_comb begin
    rx_lc    = to_lower(iRxData);
    cmd_set  = 4'b0000;
    echo_tgl = 1'b0;
    cmd_err  = 1'b0;
`ifdef UART_SCHED_AUTO_REPORT_EN
    auto_tgl = 1'b0;
    sel_ld   = 1'b0;
    sel_val  = sel_q;
`endif
    if (iRxValid) begin
      case (rx_lc)
        CMD_WATCH: cmd_set[PEND_W] = 1'b1;
        CMD_SR04:  cmd_set[PEND_S] = 1'b1;
        CMD_TEMP:  cmd_set[PEND_T] = 1'b1;
        CMD_HUM:   cmd_set[PEND_H] = 1'b1;
        CMD_ALL:   cmd_set = 4'b1111;
        CMD_ECHO:  echo_tgl = 1'b1;
        CHR_CR, CHR_LF, CHR_SP: ;
`ifdef UART_SCHED_AUTO_REPORT_EN
        CMD_AUTO:  auto_tgl = 1'b1;
        CMD_PER1:  begin sel_ld = 1'b1; sel_val = 2'd0; end
        CMD_PER2:  begin sel_ld = 1'b1; sel_val = 2'd1; end
        CMD_PER5:  begin sel_ld = 1'b1; sel_val = 2'd2; end
`endif
        default:   cmd_err = 1'b1;
      endcase
    end
  end

  // Issue decision is taken in ST_IDLE; the pulse shows during ST_ISSUE and the
  // bit clears at the same edge. A same-cycle set of that bit re-arms it.
  assign issue_oh = (state_q == ST_IDLE && iSenderIdle) ? prio_pick(pend_q) : 4'b0000;
  assign pend_d   = (pend_q & ~issue_oh) | cmd_set | per_set;

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      pend_q <= 4'b0000;
      loop_q <= 1'b1;
      err_q  <= 1'b0;
`ifdef UART_SCHED_AUTO_REPORT_EN
      auto_q <= 1'b0;
      sel_q  <= DEFAULT_PERIOD_SEL;
`endif
    end else begin
      pend_q <= pend_d;
      loop_q <= loop_q ^ echo_tgl;
      err_q  <= cmd_err;
`ifdef UART_SCHED_AUTO_REPORT_EN
      auto_q <= auto_q ^ auto_tgl;
      sel_q  <= sel_val;
`endif
    end
  end

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      state_q <= ST_IDLE;
      gap_q   <= '0;
      req_q   <= 4'b0000;
    end else begin
      req_q <= 4'b0000;
      case (state_q)
        ST_IDLE: begin
          if (|issue_oh) begin
            req_q   <= issue_oh;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          gap_q   <= GAP_W'(GAP_CYCLES - 1);
          state_q <= ST_GAP;
        end
        // Give the sender time to drop its idle flag before sampling it again.
        ST_GAP: begin
          if (gap_q == '0) state_q <= ST_WAIT_IDLE;
          else             gap_q   <= gap_q - 1'b1;
        end
        ST_WAIT_IDLE: begin
          if (iSenderIdle) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign oReqWatchReport = req_q[PEND_W];
  assign oReqSr04Report  = req_q[PEND_S];
  assign oReqTempReport  = req_q[PEND_T];
  assign oReqHumReport   = req_q[PEND_H];
  assign oLoopEn         = loop_q;
  assign oCmdErr         = err_q;

endmodule

// File: tb/tb_uart_report_scheduler.sv
module tb_uart_report_scheduler;

  localparam int GAP = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_vld = 1'b0;
  logic       sender_idle;
  logic       req_w, req_s, req_t, req_h, loop_en, auto_en, cmd_err;
  logic [1:0] per_sel;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int q_exp[$];
  int hold_busy = 0;
  int busy_cnt = 0;
  int pulses = 0;
  int errs_seen = 0;
  int last_pulse = -100000;
  int rx_cyc = 0;
  logic idle_prev = 1'b0;

  always #5 clk = ~clk;

  assign sender_idle = (hold_busy == 0) && (busy_cnt == 0);

  uart_report_scheduler #(
    .CLK_HZ(10000),
    .GAP_CYCLES(GAP),
    .DEFAULT_PERIOD_SEL(2'd0)
  ) dut (
    .iClk            (clk),
    .iRstn           (rst_n),
    .iRxData         (rx_data),
    .iRxValid        (rx_vld),
    .iSenderIdle     (sender_idle),
    .oReqWatchReport (req_w),
    .oReqSr04Report  (req_s),
    .oReqTempReport  (req_t),
    .oReqHumReport   (req_h),
    .oLoopEn         (loop_en),
    .oAutoEn         (auto_en),
    .oPeriodSel      (per_sel),
    .oCmdErr         (cmd_err)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor + scoreboard + simple sender model (busy 20 cycles per request).
  always @(negedge clk) begin
    int n;
    int id;
    n  = int'(req_w) + int'(req_s) + int'(req_t) + int'(req_h);
    id = 0;
    if (busy_cnt > 0) busy_cnt--;
    if (rst_n) begin
      if (cmd_err) errs_seen++;
      if (n > 1) chk("onehot", n, 1);
      else if (n == 1) begin
        id = req_w ? 0 : req_s ? 1 : req_t ? 2 : 3;
        pulses++;
        chk("idle_before", int'(idle_prev), 1);
        chk("spacing_ok", int'((cyc - last_pulse) >= GAP + 2), 1);
        if (q_exp.size() == 0) chk("unexpected_req", id, -1);
        else                   chk("req_order", id, q_exp.pop_front());
        last_pulse = cyc;
        busy_cnt   = 20;
      end
    end
    idle_prev = (hold_busy == 0) && (busy_cnt == 0);
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    rx_vld  = 1'b1;
    rx_cyc  = cyc;
    @(posedge clk); #1;
    rx_vld  = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((q_exp.size() != 0 || !sender_idle) && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk("drain_left", q_exp.size(), 0);
    idle_cycles(10);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"}, int'({req_w, req_s, req_t, req_h}), 0);
    chk({tag, "_err"}, int'(cmd_err), 0);
    chk({tag, "_loop"}, int'(loop_en), 1);
    chk({tag, "_auto"}, int'(auto_en), 0);
    chk({tag, "_sel"}, int'(per_sel), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int p0, e0, k, first;

    // Reset values
    idle_cycles(3);
    check_reset_outputs("rst");
    @(negedge clk); rst_n = 1'b1;
    idle_cycles(3);

    // Single 'W': watch pulse 2 cycles after the RX strobe
    e0 = errs_seen; p0 = pulses;
    q_exp.push_back(0);
    send_byte("W");
    idle_cycles(8);
    chk("w_latency", last_pulse - rx_cyc, 2);
    chk("w_count", pulses - p0, 1);
    chk("w_no_err", errs_seen - e0, 0);
    drain(100);

    // 'a' while sender busy: W,S,T,H in order only after idle
    p0 = pulses;
    @(posedge clk); #1; hold_busy = 1;
    for (int i = 0; i < 4; i++) q_exp.push_back(i);
    send_byte("a");
    idle_cycles(50);
    chk("a_held", pulses - p0, 0);
    hold_busy = 0;
    drain(400);
    chk("a_count", pulses - p0, 4);

    // Duplicate 't' merges into one request
    p0 = pulses;
    hold_busy = 1;
    q_exp.push_back(2);
    send_byte("t");
    send_byte("T");
    idle_cycles(10);
    hold_busy = 0;
    drain(200);
    idle_cycles(30);
    chk("t_merge", pulses - p0, 1);

    // Unknown bytes error; CR/LF/space are ignored
    p0 = pulses; e0 = errs_seen;
    send_byte("x");
    send_byte("Q");
    idle_cycles(4);
    chk("err_two", errs_seen - e0, 2);
    e0 = errs_seen;
    send_byte(8'h0D);
    send_byte(8'h0A);
    send_byte(8'h20);
    idle_cycles(4);
    chk("ws_no_err", errs_seen - e0, 0);
    chk("err_no_req", pulses - p0, 0);
    send_byte("e");
    idle_cycles(1);
    chk("loop_off", int'(loop_en), 0);
    send_byte("E");
    idle_cycles(1);
    chk("loop_on", int'(loop_en), 1);

`ifdef UART_SCHED_AUTO_REPORT_EN
    // Periodic bursts: 1000 ms then 2000 ms (10 cycles per ms here)
    send_byte("p");
    idle_cycles(1);
    chk("auto_on", int'(auto_en), 1);
    for (int i = 0; i < 4; i++) q_exp.push_back(i);
    p0 = pulses; k = 0;
    while (pulses == p0 && k < 12000) begin @(posedge clk); k++; end
    first = last_pulse - rx_cyc;
    chk("period1_in_window", int'(first >= 10000 && first <= 10010), 1);
    drain(400);
    chk("period1_burst", pulses - p0, 4);
    send_byte("2");
    idle_cycles(1);
    chk("sel_2000", int'(per_sel), 1);
    for (int i = 0; i < 4; i++) q_exp.push_back(i);
    p0 = pulses; k = 0;
    while (pulses == p0 && k < 22000) begin @(posedge clk); k++; end
    first = last_pulse - rx_cyc;
    chk("period2_in_window", int'(first >= 20000 && first <= 20010), 1);
    drain(400);
    send_byte("p");
    idle_cycles(1);
    chk("auto_off", int'(auto_en), 0);
`else
    // Periodic commands are not recognised in this build
    e0 = errs_seen; p0 = pulses;
    send_byte("p");
    send_byte("1");
    send_byte("2");
    send_byte("5");
    idle_cycles(4);
    chk("noauto_err", errs_seen - e0, 4);
    chk("noauto_auto", int'(auto_en), 0);
    chk("noauto_sel", int'(per_sel), 0);
    idle_cycles(30);
    chk("noauto_no_req", pulses - p0, 0);
`endif

    // Reset in the middle of an 'a' sequence, right after the S pulse
    send_byte("e");
    p0 = pulses;
    q_exp.push_back(0);
    q_exp.push_back(1);
    send_byte("a");
    k = 0;
    while (pulses - p0 < 2 && k < 200) begin @(posedge clk); k++; end
    chk("mid_ws_seen", pulses - p0, 2);
    idle_cycles(3);
    @(negedge clk); rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    idle_cycles(3);
    @(negedge clk); rst_n = 1'b1;
    p0 = pulses;
    idle_cycles(80);
    chk("midrst_no_req", pulses - p0, 0);
    chk("sb_left", q_exp.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
